ovc_credit_status_ctrl: RTL

Per-output-port controller that sequences the V output virtual channels (OVCs) of one router output port. It captures the downstream initial credit once after reset, then tracks per-OVC credit and allocation status from flit-send, credit-return, allocate and release events. From this state it drives the per-OVC full/nearly-full/empty/available flags consumed by the VC/switch allocators (VSA/SSA/SMART). One instance sits beside each output port.

---
 rtl/ovc_credit_status_ctrl_pkg.sv | 22 ++
 rtl/ovc_credit_status_ctrl_ovc_credit_counter.sv | 86 ++++++++
 rtl/ovc_credit_status_ctrl.sv | 82 ++++++++
 3 files changed

// File: rtl/ovc_credit_status_ctrl_pkg.sv
// Shared types for the output-VC credit/status controller.
// Optional credit error checking is enabled with OVC_CREDIT_ERR_CHK_EN.
package ovc_credit_status_ctrl_pkg;

  localparam int B_DEFAULT = 4;
  localparam int CRDTw     = $clog2(B_DEFAULT + 1);

  typedef enum logic {
    ST_CAPTURE = 1'b0,
    ST_RUN     = 1'b1
  } ovc_state_e;

  typedef struct packed {
    logic             avalable;
    logic             status;
    logic [CRDTw-1:0] credit;
    logic             full;
    logic             nearly_full;
    logic             empty;
  } ovc_info_t;

endpackage

// File: rtl/ovc_credit_status_ctrl_ovc_credit_counter.sv
// One OVC: saturating credit counter, captured credit ceiling and allocation status.
// With OVC_CREDIT_ERR_CHK_EN a sticky err flag reports misuse of the event inputs.
module ovc_credit_counter #(
  parameter int B  = 4,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          capture,
  input  logic [CW-1:0] init_val,
  input  logic          flit_sent,
  input  logic          credit_in,
  input  logic          allocate,
  input  logic          rel,
`ifdef OVC_CREDIT_ERR_CHK_EN
  output logic          err,
`endif
  output logic [CW-1:0] credit,
  output logic [CW-1:0] cap,
  output logic          status
);

  logic [CW-1:0] init_clamped;
  logic [CW-1:0] credit_nxt;
  logic [CW-1:0] cap_nxt;
  logic          status_nxt;

  assign init_clamped = (init_val > CW'(B)) ? CW'(B) : init_val;

  always_comb begin
    credit_nxt = credit;
    cap_nxt    = cap;
    status_nxt = status;
    if (capture) begin
      credit_nxt = init_clamped;
      cap_nxt    = init_clamped;
    end else begin
      // Simultaneous send and return cancel; otherwise saturate at 0 and cap.
      if (flit_sent && !credit_in) begin
        if (credit != '0) credit_nxt = credit - CW'(1);
      end else if (credit_in && !flit_sent) begin
        if (credit != cap) credit_nxt = credit + CW'(1);
      end
      status_nxt = (status | allocate) & ~rel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit <= '0;
      cap    <= '0;
      status <= 1'b0;
    end else begin
      credit <= credit_nxt;
      cap    <= cap_nxt;
      status <= status_nxt;
    end
  end

`ifdef OVC_CREDIT_ERR_CHK_EN
  logic err_cond;

  always_comb begin
    err_cond = 1'b0;
    if (capture) begin
      err_cond = flit_sent | credit_in | allocate | rel;
    end else begin
      err_cond = (flit_sent && !credit_in && credit == '0) ||
                 (credit_in && !flit_sent && credit == cap) ||
                 (allocate && status && !rel);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err <= 1'b0;
    else if (err_cond) err <= 1'b1;
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset && err_cond) $error("ovc_credit_counter: illegal credit/status event");
  end
`endif
`endif

endmodule

// File: rtl/ovc_credit_status_ctrl.sv
// Output-port OVC controller: captures initial credit once, then tracks credit/status per OVC.
// Define OVC_CREDIT_ERR_CHK_EN to add the sticky err_o port.
module ovc_credit_status_ctrl
  import ovc_credit_status_ctrl_pkg::*;
#(
  parameter int V              = 4,
  parameter int B              = 4,
  parameter int OVC_ALLOC_MODE = 1,
  localparam int CW            = $clog2(B + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [V*CW-1:0] credit_init_val_i,
  input  logic [V-1:0]    ovc_presence_i,
  input  logic [V-1:0]    flit_sent_i,
  input  logic [V-1:0]    credit_in_i,
  input  logic [V-1:0]    ovc_allocate_i,
  input  logic [V-1:0]    ovc_release_i,
  output logic [V*CW-1:0] credit_o,
  output logic [V-1:0]    status_o,
  output logic [V-1:0]    full_o,
  output logic [V-1:0]    nearly_full_o,
  output logic [V-1:0]    empty_o,
  output logic [V-1:0]    avalable_o,
`ifdef OVC_CREDIT_ERR_CHK_EN
  output logic [V-1:0]    err_o,
`endif
  output logic            init_done_o,
  output ovc_state_e      fsm_state
);

  ovc_state_e    state, state_nxt;
  logic [CW-1:0] cap [V];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_CAPTURE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_CAPTURE) state_nxt = ST_RUN;
  end

  assign fsm_state   = state;
  assign init_done_o = (state == ST_RUN);

  for (genvar v = 0; v < V; v++) begin : g_ovc
    ovc_credit_counter #(.B(B), .CW(CW)) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .capture   (state == ST_CAPTURE),
      .init_val  (credit_init_val_i[v*CW +: CW]),
      .flit_sent (flit_sent_i[v]),
      .credit_in (credit_in_i[v]),
      .allocate  (ovc_allocate_i[v]),
      .rel       (ovc_release_i[v]),
`ifdef OVC_CREDIT_ERR_CHK_EN
      .err       (err_o[v]),
`endif
      .credit    (credit_o[v*CW +: CW]),
      .cap       (cap[v]),
      .status    (status_o[v])
    );
  end

  // cap==0 marks a disabled OVC; it reads full and empty and is never offered.
  always_comb begin
    full_o        = '0;
    nearly_full_o = '0;
    empty_o       = '0;
    avalable_o    = '0;
    for (int v = 0; v < V; v++) begin
      full_o[v]        = (credit_o[v*CW +: CW] == '0);
      nearly_full_o[v] = (credit_o[v*CW +: CW] <= CW'(1));
      empty_o[v]       = (credit_o[v*CW +: CW] == cap[v]);
      avalable_o[v]    = init_done_o & ovc_presence_i[v] & (cap[v] != '0) & ~status_o[v] &
                         ((OVC_ALLOC_MODE != 0) ? ~full_o[v] : ~nearly_full_o[v]);
    end
  end

endmodule
